// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC injection/ejection path.
// Imported by the arbiter top and its sub-blocks.
package noc_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } inj_state_t;

  function automatic int unsigned rr_next(
    input int unsigned ptr,
    input int unsigned n
  );
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority encoder: first set request at or after ptr.
// Purely combinational, shared with the ejection-side scheduler.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_id,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;
  logic [W:0]     sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    any = 1'b0;
    // scan downward so the lowest rotated index wins
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = W'(k);
        any = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (W+1)'(N)) begin
      sum = sum - (W+1)'(N);
    end
    gnt_id = sum[W-1:0];
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin sharing of one NoC injection port,
// with credit flow control and a registered flit output.
module noc_inject_arbiter
  import noc_pkg::*;
#(
  parameter  int WIDTH   = 600,
  parameter  int NUM_REQ = 4,
  parameter  int CREDITS = 8,
  localparam int IDW     = $clog2(NUM_REQ),
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [WIDTH-1:0]   req_data [0:NUM_REQ-1],
  input  logic [NUM_REQ-1:0] req_tail,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               noc_valid,
  output logic [WIDTH-1:0]   noc_data,
  output logic               noc_tail,
  input  logic               credit_ret,
  output logic [IDW-1:0]     grant_id,
  output logic [CW-1:0]      credits,
  output logic               credit_err
);

  inj_state_t       state_q;
  inj_state_t       state_d;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win_id;
  logic             win_any;
  logic [IDW-1:0]   sel_id;
  logic             sel_ok;
  logic             sel_tail;
  logic [WIDTH-1:0] sel_data;
  logic             has_credit;
  logic             xfer;
  logic             pkt_end;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .gnt_id(win_id),
    .any   (win_any)
  );

  assign has_credit = (credits != '0);

  always_comb begin
    sel_id    = win_id;
    sel_ok    = win_any;
    req_ready = '0;
    // a locked packet keeps the port even while its owner idles
    if (state_q == LOCKED) begin
      sel_id = grant_id;
      sel_ok = 1'b1;
    end
    if (sel_ok && has_credit) begin
      req_ready[sel_id] = 1'b1;
    end
    sel_tail = req_tail[sel_id];
    sel_data = req_data[sel_id];
    xfer     = |(req_ready & req_valid);
    pkt_end  = xfer && sel_tail;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (xfer && !sel_tail) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (pkt_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      if (xfer) begin
        grant_id <= sel_id;
      end
      if (pkt_end) begin
        rr_ptr <= IDW'(rr_next(32'(sel_id), NUM_REQ));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits    <= CW'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      unique case ({xfer, credit_ret})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          // overflow return is dropped and flagged for good
          if (credits == CW'(CREDITS)) begin
            credit_err <= 1'b1;
          end else begin
            credits <= credits + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      noc_valid <= 1'b0;
      noc_data  <= '0;
      noc_tail  <= 1'b0;
    end else begin
      noc_valid <= xfer;
      if (xfer) begin
        noc_data <= sel_data;
        noc_tail <= sel_tail;
      end
    end
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter: arbitration order,
// packet locking, credit limits, bubbles and async reset.
module tb_noc_inject_arbiter;

  localparam int WIDTH   = 600;
  localparam int NUM_REQ = 4;
  localparam int CREDITS = 8;

  logic               clk;
  logic               rst;
  logic [NUM_REQ-1:0] req_valid;
  logic [WIDTH-1:0]   req_data [0:NUM_REQ-1];
  logic [NUM_REQ-1:0] req_tail;
  logic [NUM_REQ-1:0] req_ready;
  logic               noc_valid;
  logic [WIDTH-1:0]   noc_data;
  logic               noc_tail;
  logic               credit_ret;
  logic [1:0]         grant_id;
  logic [3:0]         credits;
  logic               credit_err;

  int n_chk;
  int n_err;

  noc_inject_arbiter #(
    .WIDTH  (WIDTH),
    .NUM_REQ(NUM_REQ),
    .CREDITS(CREDITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_tail  (req_tail),
    .req_ready (req_ready),
    .noc_valid (noc_valid),
    .noc_data  (noc_data),
    .noc_tail  (noc_tail),
    .credit_ret(credit_ret),
    .grant_id  (grant_id),
    .credits   (credits),
    .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst        = 1'b0;
    req_valid  = '0;
    req_tail   = '0;
    credit_ret = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i] = WIDTH'(64'hCAFE_0000 + 64'(i));
    end

    // reset values
    @(negedge clk);
    #1;
    chk("rst_valid", 64'(noc_valid), 64'd0);
    chk("rst_data", noc_data[63:0], 64'd0);
    chk("rst_tail", 64'(noc_tail), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_cred", 64'(credits), 64'd8);
    chk("rst_err", 64'(credit_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // all four send single-flit packets until credits run out
    req_valid = 4'b1111;
    req_tail  = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t1_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk("t1_gid", 64'(grant_id), 64'(k % 4));
      chk("t1_valid", 64'(noc_valid), 64'd1);
      chk("t1_data", noc_data[63:0], 64'hCAFE_0000 + 64'(k % 4));
      chk("t1_cred", 64'(credits), 64'(7 - k));
    end
    #1;
    chk("t3_ready0", 64'(req_ready), 64'd0);
    chk("t3_cred0", 64'(credits), 64'd0);

    // one credit back allows exactly one more flit
    credit_ret = 1'b1;
    #1;
    chk("t3_ret_rdy", 64'(req_ready), 64'd0);
    tick();
    credit_ret = 1'b0;
    #1;
    chk("t3_idle", 64'(noc_valid), 64'd0);
    chk("t3_cred1", 64'(credits), 64'd1);
    chk("t3_ready1", 64'(req_ready), 64'b0001);
    tick();
    chk("t3_gid", 64'(grant_id), 64'd0);
    chk("t3_valid", 64'(noc_valid), 64'd1);
    chk("t3_cred_end", 64'(credits), 64'd0);
    #1;
    chk("t3_ready_end", 64'(req_ready), 64'd0);
    req_valid = '0;

    // simultaneous transfer and return at credits == 3
    credit_ret = 1'b1;
    repeat (3) tick();
    chk("t4_cred3", 64'(credits), 64'd3);
    req_valid = 4'b0010;
    #1;
    chk("t4_ready", 64'(req_ready), 64'b0010);
    tick();
    chk("t4_cred_same", 64'(credits), 64'd3);
    chk("t4_gid", 64'(grant_id), 64'd1);
    req_valid = '0;
    repeat (5) tick();
    chk("t4_cred8", 64'(credits), 64'd8);
    chk("t4_err0", 64'(credit_err), 64'd0);
    tick();
    chk("t4_err1", 64'(credit_err), 64'd1);
    chk("t4_cred_sat", 64'(credits), 64'd8);
    credit_ret = 1'b0;

    // move the pointer to requester 1
    req_valid = 4'b1001;
    tick();
    chk("mv_gid3", 64'(grant_id), 64'd3);
    tick();
    chk("mv_gid0", 64'(grant_id), 64'd0);
    req_valid = '0;

    // three-flit packet from req1 holds off req2
    req_valid = 4'b0110;
    req_tail  = 4'b0100;
    #1;
    chk("t2_rdy_a", 64'(req_ready), 64'b0010);
    tick();
    chk("t2_gid", 64'(grant_id), 64'd1);
    #1;
    chk("t2_rdy_b", 64'(req_ready), 64'b0010);
    tick();
    req_tail = 4'b0110;
    #1;
    chk("t2_rdy_c", 64'(req_ready), 64'b0010);
    tick();
    chk("t2_tail", 64'(noc_tail), 64'd1);
    #1;
    chk("t2_rdy_d", 64'(req_ready), 64'b0100);
    tick();
    chk("t2_gid2", 64'(grant_id), 64'd2);
    chk("t2_cred", 64'(credits), 64'd2);
    req_valid = '0;

    // owner stalls for two cycles mid-packet
    req_valid = 4'b1001;
    req_tail  = 4'b0001;
    #1;
    chk("t5_rdy_a", 64'(req_ready), 64'b1000);
    tick();
    chk("t5_valid_a", 64'(noc_valid), 64'd1);
    chk("t5_gid", 64'(grant_id), 64'd3);
    chk("t5_cred1", 64'(credits), 64'd1);
    req_valid = 4'b0001;
    #1;
    chk("t5_rdy_b1", 64'(req_ready), 64'b1000);
    tick();
    chk("t5_bubble1", 64'(noc_valid), 64'd0);
    #1;
    chk("t5_rdy_b2", 64'(req_ready), 64'b1000);
    tick();
    chk("t5_bubble2", 64'(noc_valid), 64'd0);
    chk("t5_hold", noc_data[63:0], 64'hCAFE_0003);
    chk("t5_gid_hold", 64'(grant_id), 64'd3);
    req_valid = 4'b1001;
    #1;
    chk("t5_rdy_c", 64'(req_ready), 64'b1000);
    tick();
    chk("t5_valid_c", 64'(noc_valid), 64'd1);
    chk("t5_tail_c", 64'(noc_tail), 64'd0);
    chk("t5_cred0", 64'(credits), 64'd0);

    // asynchronous reset mid-packet
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", 64'(noc_valid), 64'd0);
    chk("ar_data", noc_data[63:0], 64'd0);
    chk("ar_tail", 64'(noc_tail), 64'd0);
    chk("ar_gid", 64'(grant_id), 64'd0);
    chk("ar_cred", 64'(credits), 64'd8);
    chk("ar_err", 64'(credit_err), 64'd0);
    chk("ar_ready", 64'(req_ready), 64'b0001);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
